// File: rtl/dp_ctrl_pkg.sv
// rtl/dp_ctrl_pkg.sv - shared state encoding and widths for the datapath step controller
package dp_ctrl_pkg;

  localparam int STATE_W    = 2;
  localparam int STEP_CNT_W = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'b00,
    ST_STEP   = 2'b01,
    ST_RUN    = 2'b10,
    ST_HALTED = 2'b11
  } dp_state_t;

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - 2-flop synchronizer plus stable-count debouncer for a raw button/switch
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any return to the accepted level restarts the stability count.
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dp_step_controller.sv
// rtl/dp_step_controller.sv - single-step / free-run / halt clock-enable controller for the datapath
// Optional PC breakpoint comparator compiled in with BREAKPOINT_EN.
module dp_step_controller
  import dp_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int RUN_DIV         = 25000000,
  parameter int PC_W            = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_step,
  input  logic                  run_sw,
  input  logic                  halt_in,
  input  logic [PC_W-1:0]       pc,
  input  logic [PC_W-1:0]       bp_addr,
  input  logic                  bp_valid,
  output logic                  dp_en,
  output logic [STATE_W-1:0]    state_o,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  localparam int DIV_W = $clog2(RUN_DIV);

  dp_state_t        state, state_next;
  logic             step_db, step_db_q, step_req, run_on;
  logic             bp_hit, wrap, dp_en_next;
  logic [DIV_W-1:0] div;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .rst(rst), .raw(btn_step), .level(step_db)
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk(clk), .rst(rst), .raw(run_sw), .level(run_on)
  );

`ifdef BREAKPOINT_EN
  assign bp_hit = bp_valid && (pc == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  // Last divider count: a pulse registered now appears as the divider wraps to 0.
  assign wrap = (div == DIV_W'(RUN_DIV - 1));

  always_comb begin
    state_next = state;
    dp_en_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run_on)        state_next = ST_RUN;
        else if (step_req) state_next = ST_STEP;
      end
      ST_STEP: begin
        dp_en_next = 1'b1;
        state_next = halt_in ? ST_HALTED : ST_IDLE;
      end
      ST_RUN: begin
        if (halt_in)      state_next = ST_HALTED;
        else if (!run_on) state_next = ST_IDLE;
        else if (wrap) begin
          if (bp_hit) state_next = ST_HALTED;
          else        dp_en_next = 1'b1;
        end
      end
      ST_HALTED: begin
        if (step_req && !halt_in && !run_on) state_next = ST_STEP;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dp_en     <= 1'b0;
      step_cnt  <= '0;
      div       <= '0;
      step_db_q <= 1'b0;
      step_req  <= 1'b0;
    end else begin
      state     <= state_next;
      dp_en     <= dp_en_next;
      step_db_q <= step_db;
      step_req  <= step_db & ~step_db_q;
      if (dp_en_next) step_cnt <= step_cnt + STEP_CNT_W'(1);
      if (state == ST_RUN && state_next == ST_RUN) div <= wrap ? '0 : div + DIV_W'(1);
      else                                         div <= '0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dp_step_controller.sv
// tb/tb_dp_step_controller.sv - directed self-checking bench for dp_step_controller
module tb_dp_step_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_step = 1'b0;
  logic        run_sw = 1'b0;
  logic        halt_in = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] bp_addr = 32'd0;
  logic        bp_valid = 1'b0;
  logic        dp_en;
  logic [1:0]  state_o;
  logic [15:0] step_cnt;

  int          n_checks = 0;
  int          n_err = 0;
  int          edge_n = 0;
  int          pulse_cnt = 0;
  int          pe [0:15];
  logic [1:0]  st_log [0:1023];
  logic        prev_en = 1'b0;
  logic        b2b = 1'b0;
  int          e0;

  dp_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(5), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .run_sw(run_sw), .halt_in(halt_in),
    .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .dp_en(dp_en), .state_o(state_o), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock; the modelled datapath advances pc on each enabled edge.
  task automatic tick();
    logic en;
    en = dp_en;
    @(posedge clk);
    #1;
    edge_n++;
    if (en) pc = pc + 32'd4;
    if (edge_n < 1024) st_log[edge_n] = state_o;
    if (dp_en) begin
      if (prev_en) b2b = 1'b1;
      if (pulse_cnt < 16) pe[pulse_cnt] = edge_n;
      pulse_cnt++;
    end
    prev_en = dp_en;
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_step = 1'b0; run_sw = 1'b0; halt_in = 1'b0;
    bp_valid = 1'b0; bp_addr = 32'd0; pc = 32'd0;
    tick(); tick();
    rst = 1'b0;
    pulse_cnt = 0;
    prev_en = 1'b0;
  endtask

  task automatic press_step();
    btn_step = 1'b1;
    repeat (12) tick();
    btn_step = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_dp_en", dp_en, 0);
    chk("rst_state", state_o, 0);
    chk("rst_step_cnt", step_cnt, 0);

    // single step: dp_en exactly DEBOUNCE_CYCLES+4 edges after the setup edge
    tick();
    btn_step = 1'b1;
    e0 = edge_n + 1;
    repeat (20) tick();
    btn_step = 1'b0;
    repeat (10) tick();
    chk("step_pulses", pulse_cnt, 1);
    chk("step_pulse_edge", pe[0] - e0, 8);
    chk("step_cnt_1", step_cnt, 1);
    chk("step_st_before", st_log[e0 + 6], 2'b00);
    chk("step_st_step", st_log[e0 + 7], 2'b01);
    chk("step_st_after", st_log[e0 + 8], 2'b00);

    // bounce rejection
    do_reset();
    for (int i = 0; i < 5; i++) begin
      btn_step = 1'b1; tick(); tick();
      btn_step = 1'b0; tick(); tick();
    end
    repeat (20) tick();
    chk("bounce_pulses", pulse_cnt, 0);
    chk("bounce_step_cnt", step_cnt, 0);

    // run mode: 4 pulses 5 cycles apart, then stop
    do_reset();
    run_sw = 1'b1;
    e0 = edge_n + 1;
    for (int i = 0; i < 80 && pulse_cnt < 3; i++) tick();
    chk("run_reached_3", (pulse_cnt >= 3), 1);
    run_sw = 1'b0;
    repeat (20) tick();
    chk("run_st_pre", st_log[e0 + 5], 2'b00);
    chk("run_st_entry", st_log[e0 + 6], 2'b10);
    chk("run_first_lat", pe[0] - (e0 + 6), 5);
    chk("run_gap_1", pe[1] - pe[0], 5);
    chk("run_gap_3", pe[3] - pe[2], 5);
    chk("run_pulses", pulse_cnt, 4);
    chk("run_step_cnt", step_cnt, 4);
    chk("run_state_idle", state_o, 2'b00);

    // halt_in during RUN, then a step press while still halted
    do_reset();
    run_sw = 1'b1;
    for (int i = 0; i < 30 && state_o != 2'b10; i++) tick();
    tick(); tick();
    halt_in = 1'b1;
    tick();
    chk("halt_state", state_o, 2'b11);
    run_sw = 1'b0;
    repeat (10) tick();
    press_step();
    chk("halt_step_state", state_o, 2'b11);
    chk("halt_pulses", pulse_cnt, 0);
    chk("halt_step_cnt", step_cnt, 0);

    // breakpoint at pc 0x0C
    do_reset();
    bp_valid = 1'b1;
    bp_addr  = 32'h0000000C;
    run_sw   = 1'b1;
`ifdef BREAKPOINT_EN
    for (int i = 0; i < 80 && state_o != 2'b11; i++) tick();
    chk("bp_state", state_o, 2'b11);
    chk("bp_pulses", pulse_cnt, 3);
    chk("bp_pc", pc, 32'h0000000C);
    run_sw = 1'b0;
    repeat (10) tick();
    chk("bp_still_halted", state_o, 2'b11);
    press_step();
    chk("bp_step_pulses", pulse_cnt, 4);
    chk("bp_step_pc", pc, 32'h00000010);
    chk("bp_step_state", state_o, 2'b00);
`else
    for (int i = 0; i < 80 && pulse_cnt < 5; i++) tick();
    chk("nobp_pulses", pulse_cnt, 5);
    chk("nobp_state", state_o, 2'b10);
    run_sw = 1'b0;
    repeat (12) tick();
    chk("nobp_stop", state_o, 2'b00);
`endif

    // asynchronous reset on a dp_en cycle
    do_reset();
    run_sw = 1'b1;
    for (int i = 0; i < 40 && !dp_en; i++) tick();
    chk("ar_pulse_seen", dp_en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_dp_en", dp_en, 0);
    chk("ar_state", state_o, 2'b00);
    chk("ar_step_cnt", step_cnt, 0);
    run_sw = 1'b0;
    tick();
    rst = 1'b0;
    prev_en = 1'b0;
    repeat (3) tick();
    chk("ar_after_dp_en", dp_en, 0);

    chk("dp_en_back_to_back", b2b, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
